// File: rtl/frac_clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package frac_clken_pkg;

   // Default accumulator / increment width
   localparam int ACC_W_DEF = 32;

   typedef logic [ACC_W_DEF-1:0] inc_t;

   // Lock tracker states
   typedef enum logic {
      SETTLING = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   // Increment giving one pulse every n refclk cycles: 2^acc_w / n
   function automatic logic [63:0] inc_from_div(input int unsigned acc_w,
                                                input int unsigned n);
      logic [63:0] r_val;
      if (n == 0) begin
         r_val = '0;
      end else begin
         r_val = (64'd1 << acc_w) / 64'(n);
      end
      return r_val;
   endfunction

endpackage

// File: rtl/frac_clken_ch.sv
// One channel: phase accumulator, increment register and registered
// enable / square outputs. i_clr zeroes the phase without touching inc.
module frac_clken_ch import frac_clken_pkg::*; #(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_we,
   input  logic [ACC_W-1:0] i_inc,
   output logic             o_en,
   output logic             o_sq
);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_inc;
   logic             r_en;
   logic             r_sq;
   logic [ACC_W:0]   w_sum;

   // Carry out of the accumulator is the enable pulse; MSB is the square
   assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

   // Increment register: a write lands now, the accumulate this edge still uses the old value
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inc <= '0;
      end else if (i_we) begin
         r_inc <= i_inc;
      end
   end

   // Accumulator and registered outputs; phase clear wins over accumulation
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_acc <= '0;
         r_en  <= 1'b0;
         r_sq  <= 1'b0;
      end else begin
         r_acc <= w_sum[ACC_W-1:0];
         r_en  <= w_sum[ACC_W];
         r_sq  <= w_sum[ACC_W-1];
      end
   end

   assign o_en = r_en;
   assign o_sq = r_sq;

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator in the refclk domain.
// Optional feature: define CLKEN_PHASE_ALIGN_EN to add the 'align' input,
// which zeroes every channel phase and restarts the lock count.
module frac_clken_gen import frac_clken_pkg::*; #(
   parameter int NUM_CH   = 4,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int LOCK_CYC = 16,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst,
`ifdef CLKEN_PHASE_ALIGN_EN
   input  logic              align,
`endif
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   output logic [NUM_CH-1:0] outclk_en,
   output logic [NUM_CH-1:0] outclk_sq,
   output logic              locked
);

   localparam int CNT_W = $clog2(LOCK_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYC - 1);
   localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

   logic              w_accept;
   logic              w_align;
   logic              w_disturb;
   logic [NUM_CH-1:0] w_ch_we;

   lock_state_e       r_state;
   lock_state_e       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   // Out-of-range channel numbers are dropped here, so they neither
   // program a channel nor disturb the lock tracker
   assign w_accept = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);

`ifdef CLKEN_PHASE_ALIGN_EN
   assign w_align = align;
`else
   assign w_align = 1'b0;
`endif

   // Anything that changes a rate or a phase restarts the settle count
   assign w_disturb = w_accept || w_align;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign w_ch_we[gi] = w_accept && (cfg_ch == CH_W'(gi));

         frac_clken_ch #(
            .ACC_W (ACC_W)
         ) u_ch (
            .clk   (refclk),
            .rst   (rst),
            .i_clr (w_align),
            .i_we  (w_ch_we[gi]),
            .i_inc (cfg_inc),
            .o_en  (outclk_en[gi]),
            .o_sq  (outclk_sq[gi])
         );
      end
   endgenerate

   // Lock tracker state register
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state <= SETTLING;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Lock tracker next state: settle for LOCK_CYC quiet cycles, any disturbance restarts
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         SETTLING: begin
            if (w_disturb) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = LOCKED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         LOCKED: begin
            if (w_disturb) begin
               w_state_nxt = SETTLING;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = SETTLING;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign locked = (r_state == LOCKED);

endmodule

// File: tb/tb_frac_clken_gen.sv
// Scoreboard bench for frac_clken_gen: stimulus queues expectations tagged
// with the edge number they apply to; the monitor checks them each cycle.
module tb_frac_clken_gen;

   localparam int NCH = 5;
   localparam int K_EN = 0, K_SQ = 1, K_LK = 2, K_MARK = 3, K_CNT = 4, K_GAP = 5;
   localparam logic [31:0] ALL = 32'h1F;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] exp;
      logic [31:0] mask;
      string       name;
   } exp_t;

   logic           refclk;
   logic           rst;
   logic           cfg_we;
   logic [2:0]     cfg_ch;
   logic [31:0]    cfg_inc;
   logic [NCH-1:0] outclk_en;
   logic [NCH-1:0] outclk_sq;
   logic           locked;
`ifdef CLKEN_PHASE_ALIGN_EN
   logic           align;
`endif

   exp_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   cnt3 = 0;
   int   gapbad = 0;
   int   last3 = 0;
   bit   have_last = 0;
   bit   done = 0;
   exp_t e;
   logic [31:0] act;

   frac_clken_gen #(
      .NUM_CH   (NCH),
      .ACC_W    (32),
      .LOCK_CYC (16)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
`ifdef CLKEN_PHASE_ALIGN_EN
      .align     (align),
`endif
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .outclk_en (outclk_en),
      .outclk_sq (outclk_sq),
      .locked    (locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   always @(posedge refclk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic push(input int c, input int k, input logic [31:0] ev,
                       input logic [31:0] m, input string n);
      exp_t x;
      x.cyc = c; x.kind = k; x.exp = ev; x.mask = m; x.name = n;
      sb.push_back(x);
   endtask

   // Monitor: count ch3 pulses/gaps, then check every expectation due this cycle
   always @(negedge refclk) begin
      if (outclk_en[3]) begin
         cnt3++;
         if (have_last && ((cyc - last3) < 3 || (cyc - last3) > 4)) gapbad++;
         last3 = cyc;
         have_last = 1;
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.kind == K_MARK) begin
            cnt3 = 0; gapbad = 0; have_last = 0;
         end else begin
            case (e.kind)
               K_EN:    act = 32'(outclk_en);
               K_SQ:    act = 32'(outclk_sq);
               K_LK:    act = {31'b0, locked};
               K_CNT:   act = 32'(cnt3);
               default: act = 32'(gapbad);
            endcase
            n_tests++;
            if (e.cyc != cyc) begin
               n_fail++;
               $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if ((act & e.mask) !== (e.exp & e.mask)) begin
               n_fail++;
               $display("FAIL %s @cycle %0d: got %h, expected %h (mask %h)",
                        e.name, cyc, act & e.mask, e.exp & e.mask, e.mask);
            end
         end
      end
      if (done) begin
         if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: %0d expectations never checked, expected 0", sb.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   initial begin
      int k;
      logic [31:0] en_v, sq_v;
      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0;
`ifdef CLKEN_PHASE_ALIGN_EN
      align = 1'b0;
`endif
      repeat (3) tick();
      rst = 1'b0;

      // Reset release (last reset edge = 3): silent outputs, lock at edge 19
      for (int c = 3; c <= 103; c++) begin
         push(c, K_EN, 32'h0, ALL, "rst_en");
         push(c, K_SQ, 32'h0, ALL, "rst_sq");
         if (c == 3)  push(c, K_LK, 32'h0, 32'h1, "rst_locked");
         if (c == 18) push(c, K_LK, 32'h0, 32'h1, "lock_early");
         if (c == 19) push(c, K_LK, 32'h1, 32'h1, "lock_rise");
      end
      repeat (100) tick();

      // Divide-by-2 on ch0 at edge k, divide-by-4 on ch1 at edge k+1
      k = cyc + 1;
      for (int d = 0; d <= 40; d++) begin
         en_v = '0; sq_v = '0;
         en_v[0] = (d >= 2 && d % 2 == 0);
         sq_v[0] = (d >= 1 && d % 2 == 1);
         en_v[1] = (d >= 5 && d % 4 == 1);
         sq_v[1] = (d >= 3 && (d % 4 == 3 || d % 4 == 0));
         push(k + d, K_EN, en_v, ALL, "div24_en");
         push(k + d, K_SQ, sq_v, ALL, "div24_sq");
         if (d == 0)  push(k + d, K_LK, 32'h0, 32'h1, "div_lock_drop");
         if (d == 16) push(k + d, K_LK, 32'h0, 32'h1, "div_lock_early");
         if (d == 17) push(k + d, K_LK, 32'h1, 32'h1, "div_lock_rise");
      end
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 32'h8000_0000;
      tick();
      cfg_ch = 3'd1; cfg_inc = 32'h4000_0000;
      tick();
      cfg_we = 1'b0;
      repeat (39) tick();

      // Max increment on ch2, then inc=0 at edge k+10
      k = cyc + 1;
      for (int d = 0; d <= 40; d++) begin
         en_v = '0; sq_v = '0;
         en_v[2] = (d >= 2 && d <= 10);
         sq_v[2] = (d >= 1);
         push(k + d, K_EN, en_v, 32'h4, "max_inc_en");
         if (d <= 10) push(k + d, K_SQ, sq_v, 32'h4, "max_inc_sq");
         if (d == 10) push(k + d, K_LK, 32'h0, 32'h1, "max_lock_drop");
         if (d == 25) push(k + d, K_LK, 32'h0, 32'h1, "max_lock_early");
         if (d == 26) push(k + d, K_LK, 32'h1, 32'h1, "max_lock_rise");
      end
      cfg_we = 1'b1; cfg_ch = 3'd2; cfg_inc = 32'hFFFF_FFFF;
      tick();
      cfg_we = 1'b0;
      repeat (9) tick();
      cfg_we = 1'b1; cfg_ch = 3'd2; cfg_inc = 32'h0;
      tick();
      cfg_we = 1'b0;
      repeat (30) tick();

      // Fractional 1/3 on ch3: floor(3000*0x55555555/2^32) = 999 pulses
      k = cyc + 1;
      push(k, K_MARK, 32'h0, 32'h0, "mark");
      push(k + 3000, K_CNT, 32'd999, 32'hFFFF_FFFF, "frac_count");
      push(k + 3000, K_GAP, 32'd0, 32'hFFFF_FFFF, "frac_gaps");
      cfg_we = 1'b1; cfg_ch = 3'd3; cfg_inc = 32'h5555_5555;
      tick();
      cfg_we = 1'b0;
      repeat (3000) tick();

      // Reset coincident with a write: reset wins, ch4 stays silent
      k = cyc + 1;
      for (int d = 0; d <= 20; d++) begin
         push(k + d, K_EN, 32'h0, ALL, "rstwr_en");
         push(k + d, K_SQ, 32'h0, ALL, "rstwr_sq");
         if (d == 0)  push(k + d, K_LK, 32'h0, 32'h1, "rstwr_locked");
         if (d == 15) push(k + d, K_LK, 32'h0, 32'h1, "rstwr_lock_early");
         if (d == 16) push(k + d, K_LK, 32'h1, 32'h1, "rstwr_lock_rise");
      end
      rst = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd4; cfg_inc = 32'h8000_0000;
      tick();
      rst = 1'b0; cfg_we = 1'b0;
      repeat (20) tick();

      // Out-of-range channel writes (5, 7): ignored, lock undisturbed
      k = cyc + 1;
      for (int d = 0; d <= 9; d++) begin
         push(k + d, K_LK, 32'h1, 32'h1, "oor_locked");
         push(k + d, K_EN, 32'h0, ALL, "oor_en");
      end
      cfg_we = 1'b1; cfg_ch = 3'd5; cfg_inc = 32'h8000_0000;
      tick();
      cfg_ch = 3'd7;
      tick();
      cfg_we = 1'b0;
      repeat (8) tick();

      // Highest legal channel (ch4) divide-by-2
      k = cyc + 1;
      for (int d = 0; d <= 8; d++) begin
         en_v = '0; sq_v = '0;
         en_v[4] = (d >= 2 && d % 2 == 0);
         sq_v[4] = (d % 2 == 1);
         push(k + d, K_EN, en_v, ALL, "ch4_en");
         push(k + d, K_SQ, sq_v, ALL, "ch4_sq");
         if (d == 0) push(k + d, K_LK, 32'h0, 32'h1, "ch4_lock_drop");
      end
      cfg_we = 1'b1; cfg_ch = 3'd4; cfg_inc = 32'h8000_0000;
      tick();
      cfg_we = 1'b0;
      repeat (8) tick();

`ifdef CLKEN_PHASE_ALIGN_EN
      // Misaligned ch1=1/4 and ch0=1/2, then align: first ch1 pulse meets a ch0 pulse
      cfg_we = 1'b1; cfg_ch = 3'd1; cfg_inc = 32'h4000_0000;
      tick();
      cfg_ch = 3'd0; cfg_inc = 32'h8000_0000;
      tick();
      cfg_we = 1'b0;
      repeat (3) tick();
      k = cyc + 1;
      push(k,     K_EN, 32'h0, 32'h3, "align_en0");
      push(k,     K_SQ, 32'h0, 32'h3, "align_sq0");
      push(k,     K_LK, 32'h0, 32'h1, "align_lock_drop");
      push(k + 1, K_EN, 32'h0, 32'h3, "align_en1");
      push(k + 1, K_SQ, 32'h1, 32'h3, "align_sq1");
      push(k + 2, K_EN, 32'h1, 32'h3, "align_en2");
      push(k + 2, K_SQ, 32'h2, 32'h3, "align_sq2");
      push(k + 3, K_EN, 32'h0, 32'h3, "align_en3");
      push(k + 3, K_SQ, 32'h3, 32'h3, "align_sq3");
      push(k + 4, K_EN, 32'h3, 32'h3, "align_coincide");
      push(k + 4, K_SQ, 32'h0, 32'h3, "align_sq4");
      push(k + 15, K_LK, 32'h0, 32'h1, "align_lock_early");
      push(k + 16, K_LK, 32'h1, 32'h1, "align_lock_rise");
      align = 1'b1;
      tick();
      align = 1'b0;
      repeat (20) tick();
`endif

      repeat (3) tick();
      done = 1'b1;
   end

endmodule
